// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider state encoding, default operand
// width and the iteration-counter sizing helper.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } div_state_t;

   localparam int DIV_DEFAULT_WIDTH = 4;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   // Counter holds WIDTH-1 down to 0; never let it collapse to zero bits.
   function automatic int cnt_width(input int width);
      int w;
      w = clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cla_divider4_if.sv
// Start/done handshake and operand/result bus between the sequencer and
// the divider.
interface cla_divider4_if
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/cla_addsub.sv
// N-bit carry-lookahead adder/subtractor: per-bit PFA cells feeding 4-bit
// lookahead carry groups, groups chained through their carry-out.
module cla_pfa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic p,
   output logic g,
   output logic s
);
   assign p = a ^ b;
   assign g = a & b;
   assign s = p ^ c;
endmodule

module cla_addsub #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum,
   output logic         cout
);
   localparam int NG = (N + 3) / 4;
   localparam int NP = NG * 4;

   logic [N-1:0]  b_eff;
   logic [NP-1:0] p;
   logic [NP-1:0] g;
   logic [NP:0]   c;
   logic          unused_carry;

   assign b_eff = b ^ {N{sub}};
   assign c[0]  = sub;

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_bit
         if (gi < N) begin : g_live
            cla_pfa u_pfa (
               .a (a[gi]),
               .b (b_eff[gi]),
               .c (c[gi]),
               .p (p[gi]),
               .g (g[gi]),
               .s (sum[gi])
            );
         end else begin : g_pad
            // Padding bits neither generate nor propagate.
            assign p[gi] = 1'b0;
            assign g[gi] = 1'b0;
         end
      end

      for (gi = 0; gi < NG; gi++) begin : g_grp
         logic [3:0] gp;
         logic [3:0] gg;
         logic       cin;

         assign gp  = p[4*gi +: 4];
         assign gg  = g[4*gi +: 4];
         assign cin = c[4*gi];

         assign c[4*gi+1] = gg[0] | (gp[0] & cin);
         assign c[4*gi+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
         assign c[4*gi+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                          | (&gp[2:0] & cin);
         assign c[4*gi+4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                          | (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & cin);
      end
   endgenerate

   assign cout         = c[N];
   assign unused_carry = ^c[NP:N];
endmodule

// File: rtl/cla_divider4.sv
// Sequential restoring divider: one quotient bit per clock, trial subtraction
// through the CLA add/sub datapath, start/done handshake on the slave bus.
module cla_divider4
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   cla_divider4_if.slave  bus
);
   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state_reg;
   div_state_t       state_next;

   logic [WIDTH:0]   r_reg;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             dbz_reg;

   logic             accept;
   logic             zero_div;
   logic             last_iter;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   diff;
   logic             no_borrow;
   logic             unused_r_msb;

   assign accept    = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign zero_div  = (bus.divisor == '0);
   assign last_iter = (cnt_reg == '0);

   // R stays below D, so its MSB is always clear and drops out of the shift.
   assign r_shift      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign unused_r_msb = r_reg[WIDTH];

   cla_addsub #(
      .N (WIDTH + 1)
   ) u_sub (
      .a    (r_shift),
      .b    ({1'b0, d_reg}),
      .sub  (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

   always_comb begin
      r_next = no_borrow ? diff : r_shift;
      q_next = {q_reg[WIDTH-2:0], no_borrow};
   end

   always_comb begin
      state_next = state_reg;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = zero_div ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            if (last_iter) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.done = 1'b1;
            if (accept) begin
               state_next = zero_div ? ST_DONE : ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         r_reg         <= '0;
         q_reg         <= '0;
         d_reg         <= '0;
         cnt_reg       <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            d_reg   <= bus.divisor;
            r_reg   <= '0;
            q_reg   <= bus.dividend;
            cnt_reg <= CNT_LAST;
            dbz_reg <= zero_div;
            if (zero_div) begin
               quotient_reg  <= '1;
               remainder_reg <= bus.dividend;
            end
         end else if (state_reg == ST_RUN) begin
            r_reg <= r_next;
            q_reg <= q_next;
            if (last_iter) begin
               quotient_reg  <= q_next;
               remainder_reg <= r_next[WIDTH-1:0];
            end else begin
               cnt_reg <= cnt_reg - CW'(1);
            end
         end
      end
   end

   assign bus.quotient    = quotient_reg;
   assign bus.remainder   = remainder_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_cla_divider4.sv
// Scoreboard bench for cla_divider4: expected results queued at issue time,
// popped and compared when done pulses.
module tb_cla_divider4;
   import arith_pkg::*;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   cla_divider4_if #(.WIDTH(W)) bus ();

   cla_divider4 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
      end
      sb.push_back(e);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
   endtask

   // Waits (bounded) for done, sampling 1 time unit after each rising edge.
   task automatic wait_done(output int lat, output bit ok, output int busy_cnt, output bit overlap);
      lat      = 0;
      ok       = 1'b0;
      overlap  = 1'b0;
      busy_cnt = bus.busy ? 1 : 0;
      for (int i = 0; i < 4 * W + 8 && !ok; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy && bus.done) overlap = 1'b1;
         if (bus.done) ok = 1'b1;
         else if (bus.busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags got busy/done/dbz=%b expected 000",
                  {bus.busy, bus.done, bus.div_by_zero});
      end
      n_cmp++;
      if ({bus.quotient, bus.remainder} !== '0) begin
         n_bad++;
         $display("FAIL reset_results got q=%0d r=%0d expected 0/0", bus.quotient, bus.remainder);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("reset released");
   endtask

   task automatic test_basic();
      int   lat, bc;
      bit   ok, ov;
      exp_t e;
      issue(4'd13, 4'd3);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat, ok, bc, ov);
      n_cmp++;
      if (!ok || lat != W) begin
         n_bad++;
         $display("FAIL basic_latency got ok=%0b lat=%0d expected lat=%0d", ok, lat, W);
      end
      n_cmp++;
      if (bc != W || ov) begin
         n_bad++;
         $display("FAIL basic_busy got busy_cycles=%0d overlap=%0b expected %0d/0", bc, ov, W);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
         n_bad++;
         $display("FAIL basic_result got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                  bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", e.a, e.b,
               bus.quotient, bus.remainder, bus.div_by_zero, lat);
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_done_pulse got done=%b expected 0", bus.done);
      end
   endtask

   task automatic test_div_zero();
      exp_t e;
      issue(4'd5, 4'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy} !== 2'b10) begin
         n_bad++;
         $display("FAIL dz_latency got done/busy=%b expected 10", {bus.done, bus.busy});
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
         n_bad++;
         $display("FAIL dz_result got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                  bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b", e.a, e.b,
               bus.quotient, bus.remainder, bus.div_by_zero);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.done, bus.busy, bus.div_by_zero} !== 3'b001) begin
         n_bad++;
         $display("FAIL dz_after got done/busy/dbz=%b expected 001",
                  {bus.done, bus.busy, bus.div_by_zero});
      end
   endtask

   task automatic test_sweep();
      int   lat, bc;
      bit   ok, ov;
      exp_t e;
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            issue(W'(a), W'(b));
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            wait_done(lat, ok, bc, ov);
            e = sb.pop_front();
            n_cmp++;
            if (!ok) begin
               n_bad++;
               $display("FAIL sweep_timeout op %0d/%0d got no done expected done", a, b);
            end else if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
               n_bad++;
               $display("FAIL sweep op %0d/%0d got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                        a, b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
            $display("op %0d/%0d -> q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
         end
      end
   endtask

   task automatic test_ignore_start();
      int   lat, bc;
      bit   ok, ov;
      exp_t e;
      issue(4'd9, 4'd2);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.dividend = 4'd7;
      bus.divisor  = 4'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat, ok, bc, ov);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {bus.quotient, bus.remainder} !== {e.q, e.r}) begin
         n_bad++;
         $display("FAIL ignore_start got ok=%0b q=%0d r=%0d expected q=%0d r=%0d",
                  ok, bus.quotient, bus.remainder, e.q, e.r);
      end
      $display("op %0d/%0d (7/7 ignored) -> q=%0d r=%0d", e.a, e.b, bus.quotient, bus.remainder);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL ignore_no_second got done/busy=%b expected 00", {bus.done, bus.busy});
      end
   endtask

   task automatic test_reset_mid_run();
      int   lat, bc;
      bit   ok, ov;
      exp_t e;
      issue(4'd12, 4'd5);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      n_cmp++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                  bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(4'd12, 4'd5);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat, ok, bc, ov);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != W || {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
         n_bad++;
         $display("FAIL post_reset got ok=%0b lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
                  ok, lat, bus.quotient, bus.remainder, W, e.q, e.r);
      end
      $display("op %0d/%0d after reset -> q=%0d r=%0d", e.a, e.b, bus.quotient, bus.remainder);
   endtask

   task automatic test_back_to_back();
      int   lat, bc;
      bit   ok, ov;
      exp_t e;
      issue(4'd14, 4'd4);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (W - 1) @(posedge clk);
      #1;
      issue(4'd10, 4'd3);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({bus.done, bus.busy} !== 2'b10 ||
          {bus.quotient, bus.remainder} !== {e.q, e.r}) begin
         n_bad++;
         $display("FAIL b2b_first got done/busy=%b q=%0d r=%0d expected 10 q=%0d r=%0d",
                  {bus.done, bus.busy}, bus.quotient, bus.remainder, e.q, e.r);
      end
      $display("op %0d/%0d -> q=%0d r=%0d", e.a, e.b, bus.quotient, bus.remainder);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy} !== 2'b01) begin
         n_bad++;
         $display("FAIL b2b_no_gap got done/busy=%b expected 01", {bus.done, bus.busy});
      end
      wait_done(lat, ok, bc, ov);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != W || ov ||
          {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz}) begin
         n_bad++;
         $display("FAIL b2b_second got ok=%0b lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
                  ok, lat, bus.quotient, bus.remainder, W, e.q, e.r);
      end
      $display("op %0d/%0d -> q=%0d r=%0d lat=%0d", e.a, e.b, bus.quotient, bus.remainder, lat);
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_single_pulse got done=%b expected 0", bus.done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_sweep();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
